// File: rtl/pipe_trace_pkg.sv
// Shared types and helpers for the pipeline trace recorder.
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic WRAP_STOP      = 1'b0;
  localparam logic WRAP_OVERWRITE = 1'b1;

  // Occupancy counter width: must be able to represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular entry store with first-word fall-through head and optional overwrite-oldest.
module trace_ring
  import pipe_trace_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      overwrite,
  input  logic [W-1:0]              wr_data,
  output logic [W-1:0]              rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_pop, wr_ok, ovw, wr_en;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign wr_ok  = push & (~full | do_pop);
  // Full with no pop: overwrite drags the read pointer along so count stays at DEPTH.
  assign ovw    = push & full & ~do_pop & overwrite;
  assign wr_en  = wr_ok | ovw;

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en)          wptr <= wptr + PW'(1);
      if (do_pop || ovw)  rptr <= rptr + PW'(1);
      case ({wr_ok, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Commit-event trace recorder: FSM, cycle stamping, channel masking, drain detection.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CC_W       = 16,
  parameter int unsigned IDLE_LIMIT = 8
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       arm,
  input  logic                       wrap_mode,
  input  logic [NUM_CH-1:0]          ev_valid,
  input  logic [NUM_CH*TAG_W-1:0]    ev_tag,
  input  logic [NUM_CH*DATA_W-1:0]   ev_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CC_W-1:0]            rd_cc,
  output logic [NUM_CH-1:0]          rd_mask,
  output logic [NUM_CH*TAG_W-1:0]    rd_tag,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic                       done,
  output logic [CC_W-1:0]            cycle_cnt
);

  localparam int unsigned EW = CC_W + NUM_CH + NUM_CH*TAG_W + NUM_CH*DATA_W;
  localparam int unsigned IW = $clog2(IDLE_LIMIT + 1);

  state_t                    state_q, state_d;
  logic                      capturing;
  logic [IW-1:0]             idle_q;
  logic                      seen_q;
  logic                      any_ev, push, full, empty, drain_hit, dropped, overwrote;
  logic [NUM_CH*TAG_W-1:0]   tag_m;
  logic [NUM_CH*DATA_W-1:0]  data_m;
  logic [EW-1:0]             wr_entry, rd_entry;

  assign any_ev    = |ev_valid;
  assign drain_hit = (state_q == CAPTURE) & ~any_ev & seen_q & (idle_q == IW'(IDLE_LIMIT - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm)             state_d = CAPTURE;
    else if (drain_hit)  state_d = DONE;
  end

  // An arm cycle only clears; capture resumes on the following edge.
  always_comb begin
    capturing = (state_q == CAPTURE) & ~arm;
    done      = (state_q == DONE);
  end

  always_comb begin
    tag_m  = '0;
    data_m = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ev_valid[i]) begin
        tag_m[i*TAG_W +: TAG_W]    = ev_tag[i*TAG_W +: TAG_W];
        data_m[i*DATA_W +: DATA_W] = ev_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_entry  = {cycle_cnt, ev_valid, tag_m, data_m};
  assign push      = capturing & any_ev;
  assign dropped   = push & full & ~rd_ready & (wrap_mode == WRAP_STOP);
  assign overwrote = push & full & ~rd_ready & (wrap_mode == WRAP_OVERWRITE);

  trace_ring #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ring (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .clear     (arm),
    .push      (push),
    .pop       (rd_ready),
    .overwrite (wrap_mode),
    .wr_data   (wr_entry),
    .rd_data   (rd_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign rd_valid = ~empty;
  assign {rd_cc, rd_mask, rd_tag, rd_data} = rd_entry;

  always_ff @(posedge CLOCK) begin
    if (RESET || arm) begin
      cycle_cnt <= '0;
      idle_q    <= '0;
      seen_q    <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (capturing) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CC_W'(1);
      if (any_ev) begin
        idle_q <= '0;
        seen_q <= 1'b1;
      end else if (idle_q != IW'(IDLE_LIMIT)) begin
        idle_q <= idle_q + IW'(1);
      end
      if (dropped || overwrote) overflow <= 1'b1;
      if (dropped && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed self-checking bench for pipe_trace_buffer (DEPTH=4, IDLE_LIMIT=8).
module tb_pipe_trace_buffer;

  logic        CLOCK = 1'b0;
  logic        RESET, arm, wrap_mode, rd_ready;
  logic [1:0]  ev_valid;
  logic [9:0]  ev_tag;
  logic [63:0] ev_data;
  logic        rd_valid, overflow, done;
  logic [15:0] rd_cc, drop_cnt, cycle_cnt;
  logic [1:0]  rd_mask;
  logic [9:0]  rd_tag;
  logic [63:0] rd_data;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  pipe_trace_buffer #(
    .NUM_CH     (2),
    .TAG_W      (5),
    .DATA_W     (32),
    .DEPTH      (4),
    .CC_W       (16),
    .IDLE_LIMIT (8)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .arm       (arm),
    .wrap_mode (wrap_mode),
    .ev_valid  (ev_valid),
    .ev_tag    (ev_tag),
    .ev_data   (ev_data),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_cc     (rd_cc),
    .rd_mask   (rd_mask),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  task automatic step(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ev(input logic [1:0] v, input logic [4:0] t1, input logic [4:0] t0,
                        input logic [31:0] d1, input logic [31:0] d0);
    ev_valid = v;
    ev_tag   = {t1, t0};
    ev_data  = {d1, d0};
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; arm = 1'b0; wrap_mode = 1'b0; rd_ready = 1'b0;
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    step(2);
    RESET = 1'b0;
    step();
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_done", done, 0);
    check("rst_cc", cycle_cnt, 0);
    check("rst_head", {rd_cc, rd_mask, rd_tag}, 0);
    check("rst_data", rd_data, 0);

    // Events while IDLE are ignored.
    set_ev(2'b01, 5'd0, 5'd3, 32'd0, 32'd7);
    step();
    check("idle_ignore", count, 0);
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);

    // Basic capture and drain.
    do_arm();
    check("arm_cc", cycle_cnt, 0);
    set_ev(2'b01, 5'd0, 5'd3, 32'd0, 32'd7);
    step();
    check("t1_count1", count, 1);
    check("t1_stamp0", rd_cc, 0);
    check("t1_mask", rd_mask, 2'b01);
    check("t1_tag", rd_tag, 10'd3);
    check("t1_data", rd_data, 64'd7);
    step(2);
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t1_count3", count, 3);
    step(7);
    check("t1_notdone", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_cnt_done", count, 3);
    check("t1_cycle", cycle_cnt, 11);
    set_ev(2'b01, 5'd0, 5'd1, 32'd0, 32'd1);
    step();
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("done_ignore", count, 3);
    check("done_cc_hold", cycle_cnt, 11);
    rd_ready = 1'b1;
    check("t1_pop0", rd_cc, 0);
    step();
    check("t1_pop1", rd_cc, 1);
    step();
    check("t1_pop2", rd_cc, 2);
    step();
    check("t1_empty", rd_valid, 0);
    rd_ready = 1'b0;

    // Two channels in one cycle, then ch1 only.
    do_arm();
    check("rearm_done", done, 0);
    set_ev(2'b11, 5'd9, 5'd5, 32'h55, 32'hAA);
    step();
    set_ev(2'b10, 5'd9, 5'd5, 32'h55, 32'hAA);
    step();
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t2_count", count, 2);
    check("t2_mask11", rd_mask, 2'b11);
    check("t2_tag11", rd_tag, {5'd9, 5'd5});
    check("t2_data11", rd_data, {32'h55, 32'hAA});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t2_mask10", rd_mask, 2'b10);
    check("t2_tag10", rd_tag, {5'd9, 5'd0});
    check("t2_data10", rd_data, {32'h55, 32'h0});
    check("t2_cc1", rd_cc, 1);

    // Stop-when-full.
    wrap_mode = 1'b0;
    do_arm();
    check("t3_arm_cnt", count, 0);
    for (int unsigned i = 0; i < 6; i++) begin
      set_ev(2'b01, 5'd0, 5'd2, 32'd0, 32'(i));
      step();
    end
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t3_count", count, 4);
    check("t3_drop", drop_cnt, 2);
    check("t3_ovf", overflow, 1);
    rd_ready = 1'b1;
    check("t3_head0", rd_cc, 0);
    step();
    check("t3_head1", rd_cc, 1);
    step();
    check("t3_head2", rd_cc, 2);
    step();
    check("t3_head3", {rd_cc, rd_data}, {16'd3, 64'd3});
    step();
    check("t3_empty", rd_valid, 0);
    rd_ready = 1'b0;

    // Overwrite-oldest.
    wrap_mode = 1'b1;
    do_arm();
    check("t4_arm_ovf", overflow, 0);
    check("t4_arm_drop", drop_cnt, 0);
    for (int unsigned i = 0; i < 6; i++) begin
      set_ev(2'b01, 5'd0, 5'd2, 32'd0, 32'(i));
      step();
    end
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t4_count", count, 4);
    check("t4_drop", drop_cnt, 0);
    check("t4_ovf", overflow, 1);
    rd_ready = 1'b1;
    check("t4_head2", rd_cc, 2);
    step();
    check("t4_head3", rd_cc, 3);
    step();
    check("t4_head4", rd_cc, 4);
    step();
    check("t4_head5", rd_cc, 5);
    step();
    rd_ready = 1'b0;
    check("t4_empty", count, 0);

    // Full buffer with simultaneous pop and push.
    wrap_mode = 1'b0;
    do_arm();
    for (int unsigned i = 0; i < 4; i++) begin
      set_ev(2'b01, 5'd0, 5'd1, 32'd0, 32'(i));
      step();
    end
    check("t5_full", count, 4);
    check("t5_ovf0", overflow, 0);
    set_ev(2'b01, 5'd0, 5'd1, 32'd0, 32'd4);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t5_count", count, 4);
    check("t5_ovf", overflow, 0);
    check("t5_drop", drop_cnt, 0);
    check("t5_head", rd_cc, 1);

    // Reset mid-capture, then a fresh run.
    do_arm();
    set_ev(2'b01, 5'd0, 5'd4, 32'd0, 32'd9);
    step(3);
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t6_count3", count, 3);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("t6_count", count, 0);
    check("t6_valid", rd_valid, 0);
    check("t6_cc", cycle_cnt, 0);
    check("t6_done", done, 0);
    set_ev(2'b01, 5'd0, 5'd4, 32'd0, 32'd9);
    step();
    check("t6_idle_ign", count, 0);
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    do_arm();
    set_ev(2'b01, 5'd0, 5'd6, 32'd0, 32'd12);
    step();
    set_ev(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    check("t6_stamp", rd_cc, 0);
    step(7);
    check("t6_notdone", done, 0);
    step();
    check("t6_done_again", done, 1);
    check("t6_final_cnt", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable, parametrised event-trace recorder for the pipelined CPU. It timestamps per-cycle commit events (register writeback, memory write, and more via extra channels) into a circular buffer. It detects pipeline drain as a configurable run of idle cycles after activity. The buffer is then read out through a valid/ready port, so simulation and FPGA debug share one trace path. It sits beside the CPU top level and taps writeback-stage and memory-stage signals.

## Interface
Parameters:
- NUM_CH, 2, number of event channels (ch0 = regfile writeback, ch1 = memory write by convention)
- TAG_W, 5, per-channel tag width (register index / word address bits)
- DATA_W, 32, per-channel data width
- DEPTH, 64, buffer entries; power of two, ≥ 2
- CC_W, 16, cycle-stamp width
- IDLE_LIMIT, 8, consecutive empty cycles that declare drain; ≥ 1

Ports:
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high
- arm  in  1  start or restart capture (pulse)
- wrap_mode  in  1  0 = stop-when-full (drop new), 1 = overwrite oldest
- ev_valid  in  NUM_CH  per-channel event strobe
- ev_tag  in  NUM_CH*TAG_W  channel i at [i*TAG_W +: TAG_W]
- ev_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  head entry present
- rd_cc  out  CC_W  head cycle stamp
- rd_mask  out  NUM_CH  head channel-valid mask
- rd_tag  out  NUM_CH*TAG_W  head tags (invalid channels read 0)
- rd_data  out  NUM_CH*DATA_W  head data (invalid channels read 0)
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: an event was dropped or overwritten
- drop_cnt  out  16  events dropped in stop mode, saturating
- done  out  1  state == DONE
- cycle_cnt  out  CC_W  capture-cycle counter

## Operation
- States: IDLE, CAPTURE, DONE.
  - IDLE → CAPTURE on arm.
  - CAPTURE → DONE when IDLE_LIMIT consecutive cycles have no event and at least one event has been captured since arming.
  - DONE → CAPTURE on arm.
  - arm in CAPTURE restarts capture.
- Arm entry clears buffer, count, overflow, drop_cnt, cycle_cnt, idle counter and seen-event flag.
- Capture cycle:
  - cycle_cnt increments, saturating at all-ones.
  - If |ev_valid, one entry {cycle_cnt, ev_valid, masked tags, masked data} is pushed. Simultaneous channels are lossless: one entry per cycle.
  - The idle counter clears on an event and increments otherwise, saturating at IDLE_LIMIT.
- No capture in IDLE or DONE; events are ignored and drop_cnt is unaffected.
- Readout works in every state. It is first-word fall-through: rd_* shows the head entry combinationally. A pop happens on rd_valid & rd_ready.
- Full, with no pop in the same cycle:
  - wrap_mode=0: the entry is discarded, drop_cnt +1 (saturating), overflow set.
  - wrap_mode=1: the oldest entry is overwritten, the read pointer advances, count stays DEPTH, overflow set.
- Full, with a pop and a push in the same cycle: both happen, count is unchanged, no overflow.
- Empty, with a push and rd_ready in the same cycle: no pop; the entry appears next cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

## Timing
- Reset values (RESET sampled high at an edge):
  - state IDLE.
  - rd_valid=0, rd_cc/rd_mask/rd_tag/rd_data=0 (empty buffer reads 0).
  - count=0, overflow=0, drop_cnt=0, done=0, cycle_cnt=0.
- RESET mid-capture discards all contents on that edge.
- arm sampled at edge N:
  - CAPTURE from N.
  - cycle_cnt=0 during cycle N..N+1; the first stamp written is 0.
- Event sampled at edge N is visible on rd_* and count after edge N (1-cycle latency).
- done rises at the edge that closes the IDLE_LIMIT-th consecutive empty cycle.
- arm has priority over the same-cycle drain transition.
- RESET has priority over arm.

## Structure
- Package pipe_trace_pkg:
  - state enum {IDLE, CAPTURE, DONE}
  - WRAP_STOP=1'b0, WRAP_OVERWRITE=1'b1
  - helper function for count width
- Sub-module trace_ring:
  - parametrised storage array, read/write pointers, count, full/empty
  - push/pop/overwrite controls
- The top handles the FSM, stamping, masking, idle detection and counters.

## Test plan
- Reset, arm, then ch0 events tag=3 data=7 at cycles 0,1,2, then idle (IDLE_LIMIT=8) → three entries with stamps 0,1,2; done rises at the edge closing cycle 10; count=3.
- Both channels valid in one cycle (ch0 tag=5 data=0xAA, ch1 tag=9 data=0x55) → single entry with mask=2'b11 and both payloads; next cycle ch1 only → mask=2'b10, ch0 fields read 0.
- DEPTH=4, wrap_mode=0, 6 consecutive events → count=4, entries 0..3 kept, drop_cnt=2, overflow=1.
- DEPTH=4, wrap_mode=1, 6 events → count=4, stamps read 2,3,4,5, drop_cnt=0, overflow=1.
- Full buffer with rd_ready=1 and an event in the same cycle → count stays 4, overflow stays 0, head advances by one.
- RESET asserted mid-capture with count=3 → next cycle state IDLE, count=0, rd_valid=0; arm, then done reached again with fresh stamps starting at 0.
